// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter
// with repeat frames, inter-frame gap and done pulse.
module seq_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  input  logic [3:0]       repeat_cnt,
  output logic             I,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int CW = (WIDTH > 15) ? $clog2(WIDTH + 1) : 4;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] WMAX  = CW'(WIDTH);
  localparam logic [GW-1:0] GLAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [WIDTH-1:0] pat_al;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    plen;
  logic [CW-1:0]    bitcnt;
  logic [3:0]       rep;
  logic [GW-1:0]    gapcnt;

  logic [CW-1:0]    lenx;
  logic [CW-1:0]    clen;
  logic [WIDTH-1:0] cpat;

  // clamp the requested length and left-align the pattern
  // so the first bit always sits in the top position
  always_comb begin
    lenx = CW'(len);
    clen = lenx;
    if (lenx == '0 || lenx > WMAX)
      clen = WMAX;
    cpat = pattern << (WMAX - clen);
  end

  // frame sequencer with registered serial outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pat_al <= '0;
      shreg  <= '0;
      plen   <= '0;
      bitcnt <= '0;
      rep    <= '0;
      gapcnt <= '0;
      I      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (abort && state != IDLE) begin
      state  <= IDLE;
      I      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= SHIFT;
            pat_al <= cpat;
            shreg  <= cpat << 1;
            plen   <= clen;
            bitcnt <= clen - 1'b1;
            rep    <= repeat_cnt;
            I      <= cpat[WIDTH-1];
            valid  <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (bitcnt != '0) begin
            I      <= shreg[WIDTH-1];
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - 1'b1;
          end else if (rep != '0) begin
            rep <= rep - 1'b1;
            if (GAP_CYCLES > 0) begin
              state  <= GAP;
              gapcnt <= GLAST;
              I      <= 1'b0;
              valid  <= 1'b0;
            end else begin
              shreg  <= pat_al << 1;
              bitcnt <= plen - 1'b1;
              I      <= pat_al[WIDTH-1];
            end
          end else begin
            state <= DONE;
            I     <= 1'b0;
            valid <= 1'b0;
            done  <= 1'b1;
          end
        end
        GAP: begin
          if (gapcnt == '0) begin
            state  <= SHIFT;
            shreg  <= pat_al << 1;
            bitcnt <= plen - 1'b1;
            I      <= pat_al[WIDTH-1];
            valid  <= 1'b1;
          end else begin
            gapcnt <= gapcnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          I     <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed checks of seq_pattern_tx
// with GAP_CYCLES=2 and GAP_CYCLES=0 instances.
module tb_seq_pattern_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] repeat_cnt;

  logic i_a, v_a, b_a, d_a;
  logic i_b, v_b, b_b, d_b;

  int nvec;
  int nerr;

  seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2)) dut (
    .clock(clock), .reset(reset),
    .start(start), .abort(abort),
    .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt),
    .I(i_a), .valid(v_a),
    .busy(b_a), .done(d_a)
  );

  seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset),
    .start(start), .abort(abort),
    .pattern(pattern), .len(len),
    .repeat_cnt(repeat_cnt),
    .I(i_b), .valid(v_b),
    .busy(b_b), .done(d_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic kick(input logic [7:0] p,
                      input logic [3:0] l,
                      input logic [3:0] r);
    pattern    = p;
    len        = l;
    repeat_cnt = r;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // checks n bits of p MSB-first, then the done cycle;
  // poke >= 0 re-pulses start with junk at that bit,
  // dstart holds start high during the done cycle
  task automatic frame(input string tag,
                       input logic [7:0] p,
                       input int n,
                       input int poke,
                       input logic dstart);
    logic [7:0] t;
    for (int i = 0; i < n; i++) begin
      t = p >> (n - 1 - i);
      chk($sformatf("%s_i%0d", tag, i), 32'(i_a), 32'(t[0]));
      chk($sformatf("%s_v%0d", tag, i), 32'(v_a), 32'd1);
      if (i == poke) begin
        pattern = 8'h00;
        len     = 4'd4;
        start   = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk({tag, "_done"}, 32'(d_a), 32'd1);
    chk({tag, "_dbusy"}, 32'(b_a), 32'd1);
    chk({tag, "_dvalid"}, 32'(v_a), 32'd0);
    start = dstart;
    tick();
    start = 1'b0;
    chk({tag, "_idle_busy"}, 32'(b_a), 32'd0);
    chk({tag, "_idle_done"}, 32'(d_a), 32'd0);
  endtask

  logic [14:0] ea_i, ea_v, ea_b, ea_d;
  logic [14:0] eb_i, eb_v, eb_b, eb_d;

  initial begin
    nvec       = 0;
    nerr       = 0;
    reset      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = 8'h00;
    len        = 4'd0;
    repeat_cnt = 4'd0;

    tick();
    tick();
    chk("rst_i", 32'(i_a), 32'd0);
    chk("rst_valid", 32'(v_a), 32'd0);
    chk("rst_busy", 32'(b_a), 32'd0);
    chk("rst_done", 32'(d_a), 32'd0);
    reset = 1'b1;

    // single 8-bit frame; start during DONE ignored
    kick(8'hD3, 4'd8, 4'd0);
    frame("d3", 8'hD3, 8, -1, 1'b1);
    tick();
    chk("donestart_busy", 32'(b_a), 32'd0);

    // repeats with and without gap
    ea_i = 15'b101001010010100;
    ea_v = 15'b111001110011100;
    ea_b = 15'b111111111111110;
    ea_d = 15'b000000000000010;
    eb_i = 15'b101101101000000;
    eb_v = 15'b111111111000000;
    eb_b = 15'b111111111100000;
    eb_d = 15'b000000000100000;
    kick(8'h05, 4'd3, 4'd2);
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("gap_i%0d", c), 32'(i_a), 32'(ea_i[14-c]));
      chk($sformatf("gap_v%0d", c), 32'(v_a), 32'(ea_v[14-c]));
      chk($sformatf("gap_b%0d", c), 32'(b_a), 32'(ea_b[14-c]));
      chk($sformatf("gap_d%0d", c), 32'(d_a), 32'(ea_d[14-c]));
      chk($sformatf("b2b_i%0d", c), 32'(i_b), 32'(eb_i[14-c]));
      chk($sformatf("b2b_v%0d", c), 32'(v_b), 32'(eb_v[14-c]));
      chk($sformatf("b2b_b%0d", c), 32'(b_b), 32'(eb_b[14-c]));
      chk($sformatf("b2b_d%0d", c), 32'(d_b), 32'(eb_d[14-c]));
      tick();
    end

    // async reset while bit 4 is on the line
    kick(8'hD3, 4'd8, 4'd0);
    tick();
    tick();
    tick();
    chk("prerst_i", 32'(i_a), 32'd1);
    chk("prerst_busy", 32'(b_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_i", 32'(i_a), 32'd0);
    chk("arst_valid", 32'(v_a), 32'd0);
    chk("arst_busy", 32'(b_a), 32'd0);
    chk("arst_busy0", 32'(b_b), 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("postrst_done%0d", c), 32'(d_a), 32'd0);
      chk($sformatf("postrst_busy%0d", c), 32'(b_a), 32'd0);
    end
    kick(8'hD3, 4'd8, 4'd0);
    frame("rstre", 8'hD3, 8, -1, 1'b0);

    // restart attempt mid-frame is ignored
    kick(8'hD3, 4'd8, 4'd0);
    frame("poke", 8'hD3, 8, 2, 1'b0);

    // abort on bit index 2 of the frame
    kick(8'hD3, 4'd8, 4'd0);
    tick();
    tick();
    chk("preab_i", 32'(i_a), 32'd0);
    chk("preab_busy", 32'(b_a), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_i", 32'(i_a), 32'd0);
    chk("ab_valid", 32'(v_a), 32'd0);
    chk("ab_busy", 32'(b_a), 32'd0);
    chk("ab_done", 32'(d_a), 32'd0);
    tick();
    chk("ab_done2", 32'(d_a), 32'd0);
    chk("ab_busy2", 32'(b_a), 32'd0);

    // start together with abort in IDLE
    pattern = 8'hFF;
    len     = 4'd8;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 32'(b_a), 32'd0);
    chk("sa_valid", 32'(v_a), 32'd0);

    // length clamping
    kick(8'hB1, 4'd0, 4'd0);
    frame("len0", 8'hB1, 8, -1, 1'b0);
    kick(8'h6C, 4'd12, 4'd0);
    frame("len12", 8'h6C, 8, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, giving the idle cycles between repeated frames (0 = back-to-back).
REQ-003 The block SHALL have port clock, input, 1, the sole clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port start, input, 1, a request to begin transmission, sampled on rising edge.
REQ-006 The block SHALL have port abort, input, 1, a synchronous request to cancel transmission.
REQ-007 The block SHALL have port pattern, input, WIDTH, the bits to send; bit len-1 is sent first.
REQ-008 The block SHALL have port len, input, 4, the number of bits per frame.
REQ-009 The block SHALL have port repeat_cnt, input, 4, the number of extra frames after the first.
REQ-010 The block SHALL have port I, output, 1, the serial bit stream, which drives the detector's I input.
REQ-011 The block SHALL have port valid, output, 1, high while I carries a pattern bit.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse after the last bit of the last frame.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 The FSM SHALL have exactly the states IDLE, SHIFT, GAP and DONE.
REQ-016 In IDLE, with start=1 and abort=0 at an edge, the block SHALL capture pattern, len and repeat_cnt, then enter SHIFT.
REQ-017 After the capture edge, the next cycle SHALL present the first bit (I=pattern[len-1], valid=1).
REQ-018 In SHIFT, the block SHALL output one bit per cycle, MSB-first, over bits len-1 down to 0, with valid=1.
REQ-019 len=0 or len>WIDTH SHALL be clamped to WIDTH at capture.
REQ-020 After bit 0 of a frame, if the remaining repeats are >0, the block SHALL decrement the repeat count.
REQ-021 After that decrement, it SHALL go to GAP when GAP_CYCLES>0, otherwise restart SHIFT immediately with no bubble.
REQ-022 After bit 0 of a frame, if the remaining repeats are 0, the block SHALL go to DONE.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with I=0 and valid=0, then return to SHIFT.
REQ-024 Each frame after a GAP SHALL resend the captured pattern from bit len-1.
REQ-025 DONE SHALL last one cycle with done=1, I=0, valid=0, busy=1, then go to IDLE.
REQ-026 In IDLE, I=0, valid=0, busy=0 and done=0 SHALL hold.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 Changes to pattern, len or repeat_cnt after capture SHALL have no effect until the next capture.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with I=0, valid=0, busy=0, and done not pulsed.
REQ-030 When start=1 and abort=1 together in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-031 start=1 during the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-032 The total bits sent SHALL be len*(repeat_cnt+1).
REQ-033 The cycles from the first bit to done SHALL be len*(repeat_cnt+1) + GAP_CYCLES*repeat_cnt.
REQ-034 The bit counter and repeat counter SHALL not wrap.
REQ-035 repeat_cnt=15 SHALL produce exactly 16 frames.

Reset
REQ-036 reset=0 SHALL immediately, without a clock edge, force state IDLE, I=0, valid=0, busy=0 and done=0.
REQ-037 reset=0 SHALL clear all counters and captured registers to 0.
REQ-038 Reset asserted mid-frame SHALL discard the frame; no done pulse SHALL follow.
REQ-039 After reset deasserts, the first start SHALL be accepted on the first rising edge at which reset=1.

Verification
REQ-040 Bench: pattern=8'hD3, len=8, repeat_cnt=0, start pulse -> I=1,1,0,1,0,0,1,1 over 8 cycles with valid=1, then done=1 for one cycle, then IDLE.
REQ-041 Bench: pattern=8'h05, len=3, repeat_cnt=2, GAP_CYCLES=2 -> 101,00,101,00,101; valid low in gaps; done after 13 cycles.
REQ-042 Bench: same stimulus, GAP_CYCLES=0 -> 101101101 contiguous, valid held high for 9 cycles.
REQ-043 Bench: reset=0 asynchronously at bit 4 of 8'hD3 -> outputs 0 before the next edge; no done; new start after release sends a full frame.
REQ-044 Bench: start re-pulsed mid-frame with a different pattern -> ignored, original frame completes intact; abort at bit 2 -> I=0, busy=0 next cycle, no done.
REQ-045 Bench: len=0 and len=12 -> both send all 8 bits of pattern.
